// File: rtl/tetromino_bag.sv
// 7-bag tetromino randomizer: draws each ID 0..6 once per bag in random order,
// with a bounded retry window and a lowest-unused fallback.
module tetromino_bag (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_rnd,
    input  logic        i_req,
    output logic [2:0]  o_piece,
    output logic        o_valid,
    output logic [2:0]  o_bag_left,
    output logic [7:0]  o_piece_cnt
);

    typedef enum logic {
        StDraw,
        StReady
    } state_e;

    state_e     r_state, w_state_d;
    logic [6:0] r_used, w_used_d;
    logic [2:0] r_attempt, w_attempt_d;
    logic [2:0] r_piece, w_piece_d;
    logic [7:0] r_cnt, w_cnt_d;

    logic [2:0] w_cand;
    logic [7:0] w_used_ext;
    logic       w_accept;
    logic [2:0] w_lowest;
    logic [2:0] w_pick;
    logic       w_take;
    logic [6:0] w_merged;
    logic [2:0] w_pop;

    assign w_cand     = i_rnd[31:29];
    // ID 7 is never legal, so treat it as permanently used.
    assign w_used_ext = {1'b1, r_used};
    assign w_accept   = ~w_used_ext[w_cand];

    always_comb begin
        w_lowest = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!r_used[i]) begin
                w_lowest = 3'(i);
            end
        end
    end

    always_comb begin
        w_pop = 3'd0;
        for (int i = 0; i < 7; i++) begin
            w_pop = w_pop + 3'(r_used[i]);
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_used_d    = r_used;
        w_attempt_d = r_attempt;
        w_piece_d   = r_piece;
        w_cnt_d     = r_cnt;
        w_pick      = w_cand;
        w_take      = 1'b0;
        w_merged    = r_used;

        unique case (r_state)
            StDraw: begin
                if (w_accept) begin
                    w_pick = w_cand;
                    w_take = 1'b1;
                end else if (r_attempt == 3'd7) begin
                    w_pick = w_lowest;
                    w_take = 1'b1;
                end else begin
                    w_attempt_d = r_attempt + 3'd1;
                end
                if (w_take) begin
                    w_merged    = r_used | (7'b1 << w_pick);
                    // Completing the bag clears the mask on the same edge.
                    w_used_d    = (w_merged == 7'h7F) ? 7'h00 : w_merged;
                    w_piece_d   = w_pick;
                    w_attempt_d = 3'd0;
                    w_state_d   = StReady;
                end
            end
            StReady: begin
                if (i_req) begin
                    w_state_d = StDraw;
                    w_cnt_d   = r_cnt + 8'd1;
                end
            end
            default: w_state_d = StDraw;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= StDraw;
            r_used    <= 7'h00;
            r_attempt <= 3'd0;
            r_piece   <= 3'd0;
            r_cnt     <= 8'd0;
        end else begin
            r_state   <= w_state_d;
            r_used    <= w_used_d;
            r_attempt <= w_attempt_d;
            r_piece   <= w_piece_d;
            r_cnt     <= w_cnt_d;
        end
    end

    assign o_piece     = r_piece;
    assign o_valid     = (r_state == StReady);
    assign o_bag_left  = 3'd7 - w_pop;
    assign o_piece_cnt = r_cnt;

endmodule

// File: doc/tetromino_bag.md
TETROMINO_BAG -- requirements
Module: tetromino_bag

Interface
REQ-001: clk  input  1  system clock; all state changes on its rising edge.
REQ-002: reset  input  1  synchronous, active-low reset; sampled on the clk rising edge; reset=0 resets the block.
REQ-003: rnd  input  32  free-running pseudo-random word from the 32-bit LFSR stage; a new value every cycle.
REQ-004: req  input  1  game FSM takes the offered piece; meaningful only while valid=1.
REQ-005: piece  output  3  offered tetromino ID, 0..6 (I,O,T,S,Z,J,L); value 7 is never driven.
REQ-006: valid  output  1  piece holds a drawn, unconsumed tetromino.
REQ-007: bag_left  output  3  count of IDs not yet issued from the current 7-bag, 0..7.
REQ-008: piece_cnt  output  8  count of pieces consumed since reset; wraps from 255 to 0.

Function
REQ-009: The block SHALL implement a 7-bag randomizer: each bag issues every ID 0..6 exactly once, in random order.
REQ-010: Internal state SHALL be a 7-bit used mask, a 3-bit attempt counter, and a 2-state FSM: DRAW and READY.
REQ-011: Candidate each DRAW cycle SHALL be cand = rnd[31:29].
REQ-012: In DRAW, cand is accepted if cand<7 and used[cand]=0; on acceptance: piece<=cand, used[cand]<=1, attempt<=0, state<=READY.
REQ-013: In DRAW, on rejection with attempt<7: attempt<=attempt+1, state stays DRAW.
REQ-014: In DRAW, when attempt=7 and cand is rejected: piece<=lowest-index unused ID, mark it used, attempt<=0, state<=READY. Max DRAW dwell is therefore 8 cycles.
REQ-015: If an acceptance would make used=7'h7F, used SHALL instead be cleared to 7'h00 on that same edge, which starts a new bag.
REQ-016: valid SHALL be 1 exactly when state=READY; piece SHALL be stable while valid=1.
REQ-017: In READY with req=1: state<=DRAW, piece_cnt<=piece_cnt+1 (mod 256), and valid is 0 on the next cycle.
REQ-018: In READY with req=0: hold all state.
REQ-019: req while valid=0 SHALL be ignored and SHALL have no effect on piece_cnt.
REQ-020: Latency: an accepted candidate in a DRAW cycle SHALL give valid=1 on the following cycle. With req held at 1 and immediate acceptance, a piece is issued every 2 cycles.
REQ-021: bag_left SHALL equal 7 minus popcount(used), derived combinationally from the registered mask.
REQ-022: rnd=0 (the LFSR reset state) SHALL be handled normally; cand=0 is a legal candidate.

Reset
REQ-023: On a clk edge with reset=0, the block SHALL set: state=DRAW, used=0, attempt=0, piece=0, piece_cnt=0. Consequently valid=0 and bag_left=7.
REQ-024: Reset SHALL override req and any in-progress draw, including mid-DRAW and mid-READY.
REQ-025: Drawing SHALL begin on the first edge with reset=1.

Verification
REQ-026: Basic draw: reset, then release with rnd[31:29]=5 → next cycle valid=1, piece=5, bag_left=6, piece_cnt=0.
REQ-027: Duplicate rejection: after 2 is issued and consumed, hold rnd[31:29]=2 for 3 cycles, then drive 4 → valid rises after the 4th DRAW cycle, piece=4, piece_cnt=1.
REQ-028: Fallback: empty bag, hold rnd[31:29]=7 → 8 DRAW cycles, then valid=1, piece=0, bag_left=6.
REQ-029: Bag rollover: consume 7 distinct IDs 6,5,4,3,2,1,0 → bag_left=0 is never seen, bag_left=7 after the 7th draw, and ID 6 is accepted again on the 8th draw.
REQ-030: Handshake and reset: req=1 while valid=0 → piece_cnt unchanged. Assert reset=0 mid-DRAW → next cycle valid=0, piece=0, bag_left=7, piece_cnt=0.
REQ-031: Randomized run driven by the real LFSR for 700 pieces → every aligned group of 7 issued IDs is a permutation of 0..6; piece_cnt=188 (700 mod 256).
